// File: rtl/stack_mem_pkg.sv
// rtl/stack_mem_pkg.sv - shared types and constants for the stack machine memory arbiter
package stack_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int NREQ      = 3;
  localparam int REQ_LOAD  = 0;
  localparam int REQ_STACK = 1;
  localparam int REQ_FETCH = 2;

  // Reduce a small sum (0..5) modulo 3; used to walk the round-robin ring.
  function automatic logic [1:0] wrap3(input logic [2:0] v);
    logic [2:0] r;
    r = v;
    if (r >= 3'd3) r = r - 3'd3;
    if (r >= 3'd3) r = r - 3'd3;
    return r[1:0];
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational 3-way round-robin winner selection
module rr_pick3
  import stack_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] sel
);

  logic [1:0] cand;

  // Search ptr+1, ptr+2, ptr (mod 3); first requester found wins.
  always_comb begin
    valid = 1'b0;
    sel   = ptr;
    cand  = '0;
    for (int k = 1; k <= 3; k++) begin
      cand = wrap3(3'({1'b0, ptr}) + 3'(k));
      if (!valid && req[cand]) begin
        valid = 1'b1;
        sel   = cand;
      end
    end
  end

endmodule

// File: rtl/stack_mem_arbiter.sv
// rtl/stack_mem_arbiter.sv - round-robin arbiter sharing one synchronous memory among three requesters
module stack_mem_arbiter
  import stack_mem_pkg::*;
#(
  parameter int AW     = 5,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [2:0]        we,
  input  logic [3*AW-1:0]   addr,
  input  logic [3*DW-1:0]   wdata,
  output logic [2:0]        gnt,
  output logic [2:0]        done,
  output logic [DW-1:0]     rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int CW = $clog2(RD_LAT + 1);

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      sel_q, sel_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            pick_valid;
  logic [1:0]      pick_sel;

  rr_pick3 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // State and latched transaction registers; reset clears every output source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd2;
      sel_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state: arbitrate only in IDLE, then run issue / latency wait / response.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          sel_d   = pick_sel;
          ptr_d   = pick_sel;
          state_d = ISSUE;
          for (int i = 0; i < NREQ; i++) begin
            if (pick_sel == i[1:0]) begin
              we_d    = we[i];
              addr_d  = addr[i*AW +: AW];
              wdata_d = wdata[i*DW +: DW];
            end
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(RD_LAT - 1)) begin
          rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only, so req never reaches them combinationally.
  always_comb begin
    gnt    = '0;
    done   = '0;
    mem_en = 1'b0;
    mem_we = 1'b0;
    if (state_q == ISSUE) begin
      gnt[sel_q] = 1'b1;
      mem_en     = 1'b1;
      mem_we     = we_q;
    end
    if (state_q == RESP) begin
      done[sel_q] = 1'b1;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_stack_mem_arbiter.sv
// tb/tb_stack_mem_arbiter.sv - self-checking bench for stack_mem_arbiter
module tb_stack_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init = 1'b1;

  logic [2:0]  req, we;
  logic [14:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt, done;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic        busy, mem_en, mem_we;
  logic [4:0]  mem_addr;

  logic [2:0]  req3, we3;
  logic [14:0] addr3;
  logic [23:0] wdata3;
  logic [2:0]  gnt3, done3;
  logic [7:0]  rdata3, mem_wdata3, mem_rdata3;
  logic        busy3, mem_en3, mem_we3;
  logic [4:0]  mem_addr3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stack_mem_arbiter #(.AW(5), .DW(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  stack_mem_arbiter #(.AW(5), .DW(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(we3), .addr(addr3), .wdata(wdata3),
    .gnt(gnt3), .done(done3), .rdata(rdata3), .busy(busy3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
  );

  function automatic logic [7:0] dflt(input logic [4:0] a);
    return {3'b000, a} ^ 8'h5A;
  endfunction

  // Memory for the RD_LAT=1 instance: unwritten words read as dflt(addr).
  logic [7:0]  mem [32];
  logic [31:0] wr_ok;
  logic [7:0]  rd_p;
  always @(posedge clk) begin
    if (init) begin
      wr_ok <= '0;
    end else if (mem_en && mem_we) begin
      mem[mem_addr]   <= mem_wdata;
      wr_ok[mem_addr] <= 1'b1;
    end
    rd_p <= wr_ok[mem_addr] ? mem[mem_addr] : dflt(mem_addr);
  end
  assign mem_rdata = rd_p;

  // Read-only memory for the RD_LAT=3 instance, preloaded with A5 at 03.
  logic [7:0] p3a, p3b, p3c;
  always @(posedge clk) begin
    p3a <= (mem_addr3 == 5'h03) ? 8'hA5 : dflt(mem_addr3);
    p3b <= p3a;
    p3c <= p3b;
  end
  assign mem_rdata3 = p3c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    logic [14:0] addr;
    logic [23:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        busy;
    logic        men;
    logic        mwe;
    logic [4:0]  maddr;
    logic [7:0]  mwdata;
    logic [7:0]  rdata;
  } vec_t;

  typedef struct {
    logic [2:0] done;
    logic       rd;
    logic [7:0] rdata;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  function automatic void cyc(input logic [2:0] r, input logic [2:0] w, input logic [14:0] a,
                              input logic [23:0] d, input logic [2:0] g, input logic [2:0] dn,
                              input logic b);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wdata = d;
    v.gnt = g; v.done = dn; v.busy = b;
    v.men = 1'b0; v.mwe = 1'b0; v.maddr = '0; v.mwdata = '0; v.rdata = '0;
    vecs.push_back(v);
  endfunction

  function automatic void iss(input logic [2:0] r, input logic [2:0] w, input logic [14:0] a,
                              input logic [23:0] d, input logic [2:0] g, input logic mw,
                              input logic [4:0] ma, input logic [7:0] md, input logic [7:0] rd);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wdata = d;
    v.gnt = g; v.done = '0; v.busy = 1'b1;
    v.men = 1'b1; v.mwe = mw; v.maddr = ma; v.mwdata = md; v.rdata = rd;
    vecs.push_back(v);
  endfunction

  // Scoreboard: every done must match the oldest outstanding grant.
  always @(negedge clk) begin
    if (!rst && done != 3'b000) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_done act=%0b exp=none t=%0t", done, $time);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_done", 32'(done), 32'(e.done));
        if (e.rd) chk("sb_rdata", 32'(rdata), 32'(e.rdata));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [14:0] a;
    logic [23:0] d;
    logic [2:0]  rq;
    int          s;
    bit          found;
    int          dc;

    req = '0; we = '0; addr = '0; wdata = '0;
    req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;

    // A: single write from requester 1
    a = {5'h00, 5'h03, 5'h00}; d = {8'h00, 8'hA5, 8'h00};
    cyc(3'b010, 3'b010, a, d, '0, '0, 1'b0);
    iss(3'b010, 3'b010, a, d, 3'b010, 1'b1, 5'h03, 8'hA5, '0);
    cyc('0, '0, '0, '0, '0, 3'b010, 1'b1);
    cyc('0, '0, '0, '0, '0, '0, 1'b0);
    // B: read from requester 2 at 03
    a = {5'h03, 5'h00, 5'h00};
    cyc(3'b100, '0, a, '0, '0, '0, 1'b0);
    iss(3'b100, '0, a, '0, 3'b100, 1'b0, 5'h03, '0, 8'hA5);
    cyc('0, '0, '0, '0, '0, '0, 1'b1);
    cyc('0, '0, '0, '0, '0, 3'b100, 1'b1);
    cyc('0, '0, '0, '0, '0, '0, 1'b0);
    // C: all three reading continuously; order 0,1,2,0
    a = {5'h12, 5'h11, 5'h10};
    for (int t = 0; t < 4; t++) begin
      s  = t % 3;
      rq = (t == 3) ? 3'b000 : 3'b111;
      cyc(3'b111, '0, a, '0, '0, '0, 1'b0);
      iss(3'b111, '0, a, '0, 3'(1 << s), 1'b0, 5'(5'h10 + s), '0, dflt(5'(5'h10 + s)));
      cyc(rq, '0, a, '0, '0, '0, 1'b1);
      cyc(rq, '0, a, '0, '0, 3'(1 << s), 1'b1);
    end
    cyc('0, '0, '0, '0, '0, '0, 1'b0);
    // D: 0 and 2 raise req while 1 is mid-read; 2 then 0 follow
    a = {5'h00, 5'h04, 5'h00};
    cyc(3'b010, '0, a, '0, '0, '0, 1'b0);
    iss(3'b010, '0, a, '0, 3'b010, 1'b0, 5'h04, '0, dflt(5'h04));
    a = {5'h09, 5'h00, 5'h08}; d = {8'h22, 8'h00, 8'h11};
    cyc(3'b101, 3'b101, a, d, '0, '0, 1'b1);
    cyc(3'b101, 3'b101, a, d, '0, 3'b010, 1'b1);
    cyc(3'b101, 3'b101, a, d, '0, '0, 1'b0);
    iss(3'b101, 3'b101, a, d, 3'b100, 1'b1, 5'h09, 8'h22, '0);
    cyc(3'b001, 3'b101, a, d, '0, 3'b100, 1'b1);
    cyc(3'b001, 3'b101, a, d, '0, '0, 1'b0);
    iss(3'b001, 3'b101, a, d, 3'b001, 1'b1, 5'h08, 8'h11, '0);
    cyc('0, '0, '0, '0, '0, 3'b001, 1'b1);
    cyc('0, '0, '0, '0, '0, '0, 1'b0);
    // F: back-to-back writes from requester 0, new address after each done
    for (int t = 0; t < 3; t++) begin
      a  = {10'h000, 5'(5'h14 + t)};
      d  = {16'h0000, 8'(8'h30 + t)};
      rq = (t == 2) ? 3'b000 : 3'b001;
      cyc(3'b001, 3'b001, a, d, '0, '0, 1'b0);
      iss(3'b001, 3'b001, a, d, 3'b001, 1'b1, 5'(5'h14 + t), 8'(8'h30 + t), '0);
      cyc(rq, 3'b001, {10'h000, 5'(5'h15 + t)}, {16'h0000, 8'(8'h31 + t)}, '0, 3'b001, 1'b1);
    end
    cyc('0, '0, '0, '0, '0, '0, 1'b0);
    // G: read back a written word through requester 1
    a = {5'h00, 5'h15, 5'h00};
    cyc(3'b010, '0, a, '0, '0, '0, 1'b0);
    iss(3'b010, '0, a, '0, 3'b010, 1'b0, 5'h15, '0, 8'h31);
    cyc('0, '0, '0, '0, '0, '0, 1'b1);
    cyc('0, '0, '0, '0, '0, 3'b010, 1'b1);
    cyc('0, '0, '0, '0, '0, '0, 1'b0);

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst3_busy", 32'(busy3), 32'h0);
    chk("rst3_mem_wdata", 32'(mem_wdata3), 32'h0);
    rst  = 1'b0;
    init = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk);
      #1;
      req = v.req; we = v.we; addr = v.addr; wdata = v.wdata;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(v.gnt));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(v.done));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(v.busy));
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(v.men));
      if (v.men) begin
        chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(v.mwe));
        chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(v.maddr));
        if (v.mwe) chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(v.mwdata));
      end
      if (v.gnt != 3'b000) begin
        sb_t e;
        e.done = v.gnt; e.rd = ~v.mwe; e.rdata = v.rdata;
        sb.push_back(e);
      end
    end

    // RD_LAT=3 read from requester 2: done with A5 in cycle 5
    @(posedge clk);
    #1;
    req3 = 3'b100; we3 = '0; addr3 = {5'h03, 10'h000};
    found = 1'b0; dc = 0;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("rl3_gnt", 32'(gnt3), 32'h4);
        chk("rl3_mem_en", 32'(mem_en3), 32'h1);
        chk("rl3_mem_we", 32'(mem_we3), 32'h0);
        req3 = '0;
      end
      if (done3 != 3'b000) begin
        found = 1'b1;
        dc = c;
        break;
      end
    end
    chk("rl3_found", 32'(found), 32'h1);
    chk("rl3_cycle", 32'(dc), 32'd5);
    chk("rl3_done", 32'(done3), 32'h4);
    chk("rl3_rdata", 32'(rdata3), 32'hA5);
    @(negedge clk);
    chk("rl3_busy_after", 32'(busy3), 32'h0);

    // Reset asserted during WAIT of a read: no done, outputs clear at once
    @(posedge clk);
    #1;
    req = 3'b010; we = '0; addr = {5'h00, 5'h03, 5'h00};
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt != 3'b000) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstw_gnt_seen", 32'(found), 32'h1);
    chk("rstw_gnt", 32'(gnt), 32'h2);
    req = '0;
    @(posedge clk);
    #1;
    chk("rstw_busy_wait", 32'(busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rstw_gnt_clr", 32'(gnt), 32'h0);
    chk("rstw_done_clr", 32'(done), 32'h0);
    chk("rstw_mem_en_clr", 32'(mem_en), 32'h0);
    chk("rstw_busy_clr", 32'(busy), 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstw_done_hold", 32'(done), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_done_after", 32'(done), 32'h0);

    // After reset requester 0 wins first
    @(posedge clk);
    #1;
    req = 3'b111; we = '0; addr = {5'h12, 5'h11, 5'h10};
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt != 3'b000) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstw_regnt_seen", 32'(found), 32'h1);
    chk("rstw_regnt", 32'(gnt), 32'h1);
    begin
      sb_t e;
      e.done = 3'b001; e.rd = 1'b1; e.rdata = dflt(5'h10);
      sb.push_back(e);
    end
    req = '0;
    found = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done != 3'b000) begin
        found = 1'b1;
        break;
      end
    end
    chk("rstw_redone_seen", 32'(found), 32'h1);
    @(negedge clk);
    chk("rstw_idle", 32'(busy), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
